// File: rtl/speed_meter_avg.sv
// speed_meter_avg: debounced reed period measurement, N-deep moving average of the period
// and a bit-serial restoring divider that turns the averaged period into speed.
module speed_meter_avg #(
  parameter int WIDTH     = 12,
  parameter int CNT_W     = 16,
  parameter int CIRC_W    = 8,
  parameter int AVG_LOG2  = 2,
  parameter int SCALE     = 360,
  parameter int DEB_TICKS = 20,
  parameter int TIMEOUT   = 3000,
  parameter int DIV_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tick,
  input  logic              reed,
  input  logic [CIRC_W-1:0] circ,
  input  logic              clr_max,
  output logic [WIDTH-1:0]  speed,
  output logic [WIDTH-1:0]  speed_max,
  output logic              valid,
  output logic              moving
);
  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int LOCK_W = $clog2(DEB_TICKS + 1);
  localparam int STEP_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t              state;
  logic [2:0]          reed_sync;
  logic [LOCK_W-1:0]   lock;
  logic [CNT_W-1:0]    period_cnt;
  logic                acc;
  logic                timeout_hit;

  logic [CNT_W-1:0]    hist [N];
  logic [SUM_W-1:0]    sum;
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [CNT_W-1:0]    upd_period;
  logic                upd_all;
  logic                upd_ring;
  logic                div_start;

  logic [DIV_W-1:0]    dividend;
  logic [DIV_W-1:0]    divisor;
  logic [DIV_W-1:0]    quot;
  logic [DIV_W-1:0]    rem;
  logic [DIV_W:0]      rem_sh;
  logic [DIV_W-1:0]    diff;
  logic                ge;
  logic [STEP_W-1:0]   steps;
  logic                busy;
  logic                publish;
  logic [WIDTH-1:0]    q_sat;

  // The edge wins over a same-cycle timeout: the counter is cleared instead.
  assign acc         = en && reed_sync[1] && !reed_sync[2] && (lock == '0);
  assign timeout_hit = en && tick && !acc && (state != IDLE) &&
                       (period_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      reed_sync  <= '0;
      lock       <= '0;
      period_cnt <= '0;
    end else begin
      reed_sync <= {reed_sync[1:0], reed};
      if (en) begin
        if (acc) begin
          lock       <= LOCK_W'(DEB_TICKS);
          period_cnt <= '0;
        end else begin
          if (tick && lock != '0) lock <= lock - LOCK_W'(1);
          if (tick && period_cnt != CNT_W'(TIMEOUT)) period_cnt <= period_cnt + CNT_W'(1);
        end
      end
    end
  end

  // FSM plus history: the accepted period lands in the history one clock after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      moving     <= 1'b0;
      upd_all    <= 1'b0;
      upd_ring   <= 1'b0;
      upd_period <= '0;
      div_start  <= 1'b0;
      sum        <= '0;
      wr_ptr     <= '0;
      // NOTE: the history is tiny and must read as zero after reset, so it lives in flops with reset.
      for (int i = 0; i < N; i++) hist[i] <= '0;
    end else if (en) begin
      upd_all   <= 1'b0;
      upd_ring  <= 1'b0;
      div_start <= 1'b0;
      if (timeout_hit) begin
        state  <= IDLE;
        moving <= 1'b0;
        sum    <= '0;
        wr_ptr <= '0;
        for (int i = 0; i < N; i++) hist[i] <= '0;
      end else begin
        if (acc) begin
          upd_period <= period_cnt;
          case (state)
            IDLE:    state <= ARMED;
            ARMED: begin
              state   <= RUN;
              moving  <= 1'b1;
              upd_all <= 1'b1;
            end
            default: upd_ring <= 1'b1;
          endcase
        end
        if (upd_all) begin
          for (int i = 0; i < N; i++) hist[i] <= upd_period;
          sum       <= SUM_W'(upd_period) << AVG_LOG2;
          div_start <= 1'b1;
        end else if (upd_ring) begin
          hist[wr_ptr] <= upd_period;
          sum          <= sum - SUM_W'(hist[wr_ptr]) + SUM_W'(upd_period);
          wr_ptr       <= wr_ptr + AVG_LOG2'(1);
          div_start    <= 1'b1;
        end
      end
    end
  end

  assign dividend = (DIV_W'(circ) * DIV_W'(SCALE)) << AVG_LOG2;
  assign rem_sh   = {rem, quot[DIV_W-1]};
  assign ge       = rem_sh >= {1'b0, divisor};
  // The true difference is below the divisor, so the low DIV_W bits are exact.
  assign diff     = rem_sh[DIV_W-1:0] - divisor;
  assign q_sat    = (|quot[DIV_W-1:WIDTH]) ? {WIDTH{1'b1}} : quot[WIDTH-1:0];
  assign publish  = busy && (steps == '0) && !div_start && !timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      steps     <= '0;
      rem       <= '0;
      quot      <= '0;
      divisor   <= '0;
      speed     <= '0;
      speed_max <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (en) begin
        if (timeout_hit) begin
          busy  <= 1'b0;
          speed <= '0;
          valid <= 1'b1;
        end else if (div_start) begin
          busy    <= 1'b1;
          steps   <= STEP_W'(DIV_W);
          rem     <= '0;
          quot    <= dividend;
          divisor <= DIV_W'(sum);
        end else if (busy && steps != '0) begin
          steps <= steps - STEP_W'(1);
          rem   <= ge ? diff : rem_sh[DIV_W-1:0];
          quot  <= {quot[DIV_W-2:0], ge};
        end else if (busy) begin
          busy  <= 1'b0;
          speed <= q_sat;
          valid <= 1'b1;
        end

        if (clr_max) speed_max <= '0;
        else if (publish && q_sat > speed_max) speed_max <= q_sat;
      end
    end
  end

endmodule

// File: tb/tb_speed_meter_avg.sv
// tb_speed_meter_avg: directed bench with a speed scoreboard per instance; the second
// instance runs with a one-tick lockout for the saturation and speed_max steps.
`timescale 1ns/1ps
module tb_speed_meter_avg;
  localparam int WIDTH  = 12;
  localparam int CIRC_W = 8;
  localparam int DIV_W  = 32;

  logic              clk = 1'b0;
  logic              rst, en, tick, reed, reed2, clr_max;
  logic [CIRC_W-1:0] circ;
  logic [WIDTH-1:0]  speed1, speed_max1, speed2, speed_max2;
  logic              valid1, moving1, valid2, moving2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int acc_cyc = 0;
  int valid_cyc = 0;
  int n_valid1 = 0;
  int q1[$];
  int q2[$];

  speed_meter_avg u_dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .reed(reed), .circ(circ),
    .clr_max(clr_max), .speed(speed1), .speed_max(speed_max1), .valid(valid1), .moving(moving1)
  );

  speed_meter_avg #(.DEB_TICKS(1)) u_dut_fast (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .reed(reed2), .circ(circ),
    .clr_max(clr_max), .speed(speed2), .speed_max(speed_max2), .valid(valid2), .moving(moving2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      clk_n(1);
    end
  endtask

  // Reed pulse with no tick nearby; acceptance registers on the third clock edge.
  task automatic pulse(input bit which);
    if (which) reed2 = 1'b1;
    else       reed  = 1'b1;
    acc_cyc = cyc_cnt + 3;
    clk_n(3);
    reed  = 1'b0;
    reed2 = 1'b0;
    clk_n(1);
  endtask

  task automatic drain();
    int k = 0;
    while ((q1.size() + q2.size()) != 0 && k < 200) begin
      clk_n(1);
      k++;
    end
    check("drain q1", q1.size(), 0);
    check("drain q2", q2.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(1);
  endtask

  always @(negedge clk) begin
    if (valid1) begin
      valid_cyc = cyc_cnt;
      n_valid1++;
      check("sb1 pending", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) check("sb1 speed", 32'(speed1), q1.pop_front());
    end
    if (valid2) begin
      check("sb2 pending", 32'(q2.size() > 0), 1);
      if (q2.size() > 0) check("sb2 speed", 32'(speed2), q2.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2[4] = '{576, 480, 411, 360};
    int base;
    rst = 1'b1; en = 1'b1; tick = 1'b0; reed = 1'b0; reed2 = 1'b0; clr_max = 1'b0;
    circ = 8'd200;
    clk_n(3);
    rst = 1'b0;
    clk_n(1);
    check("reset speed", 32'(speed1), 0);
    check("reset speed_max", 32'(speed_max1), 0);
    check("reset valid", 32'(valid1), 0);
    check("reset moving", 32'(moving1), 0);

    // Steady 100-tick period
    pulse(0);
    wait_ticks(100);
    check("armed not moving", 32'(moving1), 0);
    q1.push_back(720);
    pulse(0);
    check("moving in run", 32'(moving1), 1);
    for (int i = 0; i < 2; i++) begin
      wait_ticks(100);
      q1.push_back(720);
      pulse(0);
    end

    // Averaging step to a 200-tick period
    for (int i = 0; i < 4; i++) begin
      wait_ticks(200);
      q1.push_back(exp2[i]);
      pulse(0);
    end
    drain();
    check("valid count s1+s2", n_valid1, 7);
    check("speed_max s2", 32'(speed_max1), 720);

    // Bounce pulses 2 and 10 ticks after each accepted edge
    do_reset();
    base = n_valid1;
    pulse(0);
    for (int i = 0; i < 3; i++) begin
      wait_ticks(2);
      pulse(0);
      wait_ticks(8);
      pulse(0);
      wait_ticks(90);
      q1.push_back(720);
      pulse(0);
    end
    drain();
    check("bounce valid count", n_valid1 - base, 3);
    check("bounce speed", 32'(speed1), 720);

    // Standstill timeout exactly 3000 ticks after the last edge
    q1.push_back(0);
    wait_ticks(2999);
    check("moving before timeout", 32'(moving1), 1);
    wait_ticks(1);
    check("moving after timeout", 32'(moving1), 0);
    check("speed after timeout", 32'(speed1), 0);
    check("timeout valid cycle", valid_cyc, cyc_cnt - 1);
    pulse(0);
    wait_ticks(100);
    q1.push_back(720);
    pulse(0);
    clk_n(40);
    check("latency", valid_cyc - acc_cyc, DIV_W + 3);
    drain();

    // en low mid-division stretches latency by the frozen clocks
    wait_ticks(100);
    q1.push_back(720);
    pulse(0);
    clk_n(10);
    en = 1'b0;
    clk_n(5);
    en = 1'b1;
    clk_n(40);
    check("latency en hold", valid_cyc - acc_cyc, DIV_W + 8);
    drain();

    // Reset mid-division: no publication, everything back to zero
    wait_ticks(100);
    base = n_valid1;
    pulse(0);
    clk_n(10);
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
    check("rst speed", 32'(speed1), 0);
    check("rst speed_max", 32'(speed_max1), 0);
    check("rst valid", 32'(valid1), 0);
    check("rst moving", 32'(moving1), 0);
    clk_n(50);
    check("rst no valid", n_valid1 - base, 0);

    // Saturation and speed_max on the short-lockout instance
    circ = 8'd255;
    pulse(1);
    wait_ticks(2);
    q2.push_back(4095);
    pulse(1);
    clk_n(40);
    check("sat speed_max", 32'(speed_max2), 4095);
    wait_ticks(100);
    q2.push_back(3464);
    pulse(1);
    clk_n(40);
    check("max holds", 32'(speed_max2), 4095);
    clr_max = 1'b1;
    clk_n(1);
    clr_max = 1'b0;
    check("max cleared", 32'(speed_max2), 0);
    wait_ticks(100);
    q2.push_back(1800);
    pulse(1);
    clk_n(40);
    check("max after clear", 32'(speed_max2), 1800);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
